// File: rtl/seg7_scan_capture_if.sv
// rtl/seg7_scan_capture_if.sv - display scan bus and captured frame outputs
interface seg7_scan_capture_if;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] digits;
   logic [3:0]  blank_mask;
   logic        frame_valid;
   logic        frame_err;

   modport master (
      output an, seg,
      input  digits, blank_mask, frame_valid, frame_err
   );

   modport slave (
      input  an, seg,
      output digits, blank_mask, frame_valid, frame_err
   );
endinterface

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - deglitch a muxed active-low 7-seg bus into 4-digit frames
module seg7_scan_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input logic               clk,
   input logic               rst_n,
   seg7_scan_capture_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] HELD  = 2'd2;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [3:0]  an_m, an_s, an_p;
   logic [6:0]  seg_m, seg_s, seg_p;
   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [3:0]  seen;
   logic [15:0] stage_dig;
   logic [3:0]  stage_blank;
   logic        stage_err;
   logic [15:0] digits_r;
   logic [3:0]  blank_r;
   logic        fv_r;
   logic        err_r;

   logic        an_valid;
   logic        pair_chg;
   logic [3:0]  slot_oh;
   logic [3:0]  nib;
   logic        is_blank;
   logic        is_inv;
   logic        capture;
   logic        frame_done;
   logic [15:0] stage_dig_nx;
   logic [3:0]  stage_blank_nx;
   logic        stage_err_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_m  <= 4'hF;
         an_s  <= 4'hF;
         seg_m <= 7'h7F;
         seg_s <= 7'h7F;
      end else begin
         an_m  <= bus.an;
         an_s  <= an_m;
         seg_m <= bus.seg;
         seg_s <= seg_m;
      end
   end

   always_comb begin
      an_valid = 1'b0;
      case (an_s)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: an_valid = 1'b1;
         default:                            an_valid = 1'b0;
      endcase
   end

   // The captured slot always comes from the stored pair, which equals an_s while stable
   always_comb begin
      nib      = 4'hE;
      is_blank = 1'b0;
      is_inv   = 1'b0;
      case (seg_p)
         7'h40:   nib = 4'h0;
         7'h79:   nib = 4'h1;
         7'h24:   nib = 4'h2;
         7'h30:   nib = 4'h3;
         7'h19:   nib = 4'h4;
         7'h12:   nib = 4'h5;
         7'h02:   nib = 4'h6;
         7'h78:   nib = 4'h7;
         7'h00:   nib = 4'h8;
         7'h10:   nib = 4'h9;
         7'h7F: begin
            nib      = 4'hF;
            is_blank = 1'b1;
         end
         default: begin
            nib    = 4'hE;
            is_inv = 1'b1;
         end
      endcase
   end

   assign slot_oh    = ~an_p;
   assign pair_chg   = (an_s != an_p) || (seg_s != seg_p);
   assign capture    = (state == TRACK) && !pair_chg && ((cnt + 8'd1) == STABLE);
   assign frame_done = capture && ((seen | slot_oh) == 4'hF);

   always_comb begin
      stage_dig_nx   = stage_dig;
      stage_blank_nx = stage_blank;
      for (int k = 0; k < 4; k++) begin
         if (slot_oh[k]) begin
            stage_dig_nx[4*k +: 4] = nib;
            stage_blank_nx[k]      = is_blank;
         end
      end
      stage_err_nx = stage_err | is_inv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         an_p        <= 4'hF;
         seg_p       <= 7'h7F;
         seen        <= 4'h0;
         stage_dig   <= 16'h0000;
         stage_blank <= 4'h0;
         stage_err   <= 1'b0;
         digits_r    <= 16'h0000;
         blank_r     <= 4'h0;
         fv_r        <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         fv_r <= 1'b0;
         case (state)
            IDLE: begin
               if (an_valid) begin
                  state <= TRACK;
                  cnt   <= 8'd1;
                  an_p  <= an_s;
                  seg_p <= seg_s;
               end
            end
            TRACK, HELD: begin
               if (pair_chg) begin
                  an_p  <= an_s;
                  seg_p <= seg_s;
                  if (an_valid) begin
                     state <= TRACK;
                     cnt   <= 8'd1;
                  end else begin
                     state <= IDLE;
                     cnt   <= 8'd0;
                  end
               end else if (state == TRACK) begin
                  // cnt stops at STABLE on capture; HELD leaves it there
                  cnt <= cnt + 8'd1;
                  if (capture)
                     state <= HELD;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase

         if (capture) begin
            stage_dig   <= stage_dig_nx;
            stage_blank <= stage_blank_nx;
            if (frame_done) begin
               digits_r  <= stage_dig_nx;
               blank_r   <= stage_blank_nx;
               err_r     <= stage_err_nx;
               fv_r      <= 1'b1;
               seen      <= 4'h0;
               stage_err <= 1'b0;
            end else begin
               seen      <= seen | slot_oh;
               stage_err <= stage_err_nx;
            end
         end
      end
   end

   assign bus.digits      = digits_r;
   assign bus.blank_mask  = blank_r;
   assign bus.frame_valid = fv_r;
   assign bus.frame_err   = err_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - scoreboard bench for seg7_scan_capture
module tb_seg7_scan_capture;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   frames = 0;
   int   exp_frames = 0;
   bit   prev_fv = 1'b0;
   logic [20:0] sb[$];
   logic [20:0] mon_exp;

   seg7_scan_capture_if bus ();

   seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] sc(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic put(input int slot, input logic [6:0] s, input int n);
      logic [3:0] oh;
      oh = 4'b0001 << slot;
      bus.an  = ~oh;
      bus.seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic gap(input int n);
      bus.an  = 4'hF;
      bus.seg = 7'h7F;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_frame(input logic [15:0] d, input logic [3:0] b, input logic e);
      sb.push_back({d, b, e});
      exp_frames++;
   endtask

   task automatic check_zero_outputs(input string tag);
      checks++;
      assert (bus.digits === 16'h0000) else begin
         failures++; $error("FAIL %s_digits observed=%h expected=0000", tag, bus.digits);
      end
      checks++;
      assert (bus.blank_mask === 4'h0) else begin
         failures++; $error("FAIL %s_blank observed=%h expected=0", tag, bus.blank_mask);
      end
      checks++;
      assert (bus.frame_valid === 1'b0) else begin
         failures++; $error("FAIL %s_fv observed=%b expected=0", tag, bus.frame_valid);
      end
      checks++;
      assert (bus.frame_err === 1'b0) else begin
         failures++; $error("FAIL %s_err observed=%b expected=0", tag, bus.frame_err);
      end
   endtask

   task automatic check_frames(input string tag);
      checks++;
      assert (frames === exp_frames) else begin
         failures++; $error("FAIL %s_frames observed=%0d expected=%0d", tag, frames, exp_frames);
      end
   endtask

   always @(negedge clk) begin
      if (bus.frame_valid === 1'b1) begin
         checks++;
         assert (!prev_fv) else begin
            failures++; $error("FAIL fv_pulse observed=high_twice expected=single_cycle");
         end
         checks++;
         assert (sb.size() > 0) else begin
            failures++; $error("FAIL frame_unexpected observed=%h expected=no_frame", bus.digits);
         end
         if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            checks++;
            assert (bus.digits === mon_exp[20:5]) else begin
               failures++; $error("FAIL digits observed=%h expected=%h", bus.digits, mon_exp[20:5]);
            end
            checks++;
            assert (bus.blank_mask === mon_exp[4:1]) else begin
               failures++; $error("FAIL blank_mask observed=%b expected=%b", bus.blank_mask, mon_exp[4:1]);
            end
            checks++;
            assert (bus.frame_err === mon_exp[0]) else begin
               failures++; $error("FAIL frame_err observed=%b expected=%b", bus.frame_err, mon_exp[0]);
            end
         end
         frames++;
      end
      prev_fv = (bus.frame_valid === 1'b1);
   end

   initial begin
      rst_n   = 1'b0;
      bus.an  = 4'hF;
      bus.seg = 7'h7F;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      gap(4);

      // basic scan 1,2,3,4
      expect_frame(16'h4321, 4'h0, 1'b0);
      for (int k = 0; k < 4; k++) put(k, sc(k + 1), 10);
      gap(10);
      check_frames("basic");

      // short dwell on slot 2 must not count
      put(2, sc(7), 3);
      gap(3);
      put(0, sc(5), 10);
      put(1, sc(6), 10);
      put(3, sc(9), 10);
      gap(10);
      check_frames("short_dwell");
      expect_frame(16'h9865, 4'h0, 1'b0);
      put(2, sc(8), 10);
      gap(10);
      check_frames("short_dwell_done");

      // blank and invalid patterns, then a clean frame clears err
      expect_frame(16'hE2F0, 4'b0010, 1'b1);
      put(0, sc(0), 10);
      put(1, 7'h7F, 10);
      put(2, sc(2), 10);
      put(3, 7'h7E, 10);
      gap(10);
      expect_frame(16'h8888, 4'h0, 1'b0);
      for (int k = 0; k < 4; k++) put(k, sc(8), 10);
      gap(10);
      check_frames("blank_inv");

      // two digits lit is ignored; partial frame survives it
      put(0, sc(2), 10);
      put(1, sc(4), 10);
      bus.an  = 4'b0011;
      bus.seg = sc(3);
      repeat (20) @(negedge clk);
      check_frames("multi_lit");
      expect_frame(16'h8642, 4'h0, 1'b0);
      put(2, sc(6), 10);
      put(3, sc(8), 10);
      gap(10);
      check_frames("multi_lit_done");

      // ghosting on slot 0 settles to 1
      expect_frame(16'h7531, 4'h0, 1'b0);
      for (int i = 0; i < 6; i++) put(0, (i % 2 == 0) ? sc(0) : sc(1), 2);
      put(0, sc(1), 10);
      put(1, sc(3), 10);
      put(2, sc(5), 10);
      put(3, sc(7), 10);
      gap(10);
      check_frames("ghost");

      // reset mid-frame discards partial collection
      put(1, sc(1), 10);
      put(2, sc(1), 10);
      put(3, sc(1), 10);
      #3 rst_n = 1'b0;
      #1 check_zero_outputs("midreset");
      gap(2);
      rst_n = 1'b1;
      gap(4);
      put(0, sc(6), 10);
      gap(10);
      check_frames("post_reset_partial");
      expect_frame(16'h9876, 4'h0, 1'b0);
      put(1, sc(7), 10);
      put(2, sc(8), 10);
      put(3, sc(9), 10);
      gap(10);
      check_frames("post_reset_frame");

      checks++;
      assert (sb.size() === 0) else begin
         failures++; $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
